// File: rtl/xbee_msg_tx.sv
// Framed ASCII message UART transmitter for the XBee link.
// Serialises one GBI/POS/END message per accepted request, 8N(STOP_BITS), LSB first.
module xbee_msg_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 2
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [1:0] msg_type,
  input  logic [3:0] bin_number,
  input  logic [1:0] colour,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic          stop_cnt;
  logic [3:0]    char_idx;
  logic [1:0]    lat_type;
  logic [3:0]    lat_bin;
  logic [1:0]    lat_col;

  logic [7:0] cur_char;
  logic [7:0] d_char;
  logic [7:0] c_char;
  logic [3:0] last_idx;
  logic [2:0] nxt_bit;
  logic       bit_end;
  logic       accept;

  assign bit_end = (clk_cnt == CNT_LAST);
  assign nxt_bit = bit_idx + 3'd1;
  assign accept  = tx_start && !busy && (msg_type != 2'd3);

  always_comb begin
    d_char = (lat_bin < 4'd10) ? (8'h30 + {4'h0, lat_bin}) : 8'h3F;
    case (lat_col)
      2'd0:    c_char = 8'h4D;
      2'd1:    c_char = 8'h44;
      2'd2:    c_char = 8'h57;
      default: c_char = 8'h58;
    endcase
    case (lat_type)
      2'd0:    last_idx = 4'd8;
      2'd1:    last_idx = 4'd6;
      default: last_idx = 4'd5;
    endcase
    cur_char = 8'h0A;
    case (lat_type)
      2'd0: begin
        case (char_idx)
          4'd0:    cur_char = 8'h47;
          4'd1:    cur_char = 8'h42;
          4'd2:    cur_char = 8'h49;
          4'd3:    cur_char = d_char;
          4'd4:    cur_char = 8'h2D;
          4'd5:    cur_char = c_char;
          4'd6:    cur_char = 8'h2D;
          4'd7:    cur_char = 8'h23;
          default: cur_char = 8'h0A;
        endcase
      end
      2'd1: begin
        case (char_idx)
          4'd0:    cur_char = 8'h50;
          4'd1:    cur_char = 8'h4F;
          4'd2:    cur_char = 8'h53;
          4'd3:    cur_char = d_char;
          4'd4:    cur_char = 8'h2D;
          4'd5:    cur_char = 8'h23;
          default: cur_char = 8'h0A;
        endcase
      end
      default: begin
        case (char_idx)
          4'd0:    cur_char = 8'h45;
          4'd1:    cur_char = 8'h4E;
          4'd2:    cur_char = 8'h44;
          4'd3:    cur_char = 8'h2D;
          4'd4:    cur_char = 8'h23;
          default: cur_char = 8'h0A;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      char_idx <= '0;
      lat_type <= '0;
      lat_bin  <= '0;
      lat_col  <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE accepts like IDLE so a held request chains with only the done cycle between messages
        S_IDLE, S_DONE: begin
          state   <= S_IDLE;
          clk_cnt <= '0;
          if (accept) begin
            lat_type <= msg_type;
            lat_bin  <= bin_number;
            lat_col  <= colour;
            char_idx <= '0;
            state    <= S_START;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_START: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
          if (bit_end) begin
            state   <= S_DATA;
            bit_idx <= '0;
            tx      <= cur_char[0];
          end
        end
        S_DATA: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state    <= S_STOP;
              stop_cnt <= 1'b0;
              tx       <= 1'b1;
            end else begin
              bit_idx <= nxt_bit;
              tx      <= cur_char[nxt_bit];
            end
          end
        end
        S_STOP: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
          if (bit_end) begin
            if (stop_cnt == STOP_LAST) begin
              if (char_idx == last_idx) begin
                state    <= S_DONE;
                char_idx <= '0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end else begin
                char_idx <= char_idx + 4'd1;
                state    <= S_START;
                tx       <= 1'b0;
              end
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xbee_msg_tx.sv
// Directed bench for xbee_msg_tx: three instances cover (4,2), (4,1) and default timing.
module tb_xbee_msg_tx;

  logic       clk_50M = 1'b0;
  logic       rst_n;
  logic [2:0] start;
  logic [1:0] msg_type;
  logic [3:0] bin_number;
  logic [1:0] colour;
  logic       tx_a, busy_a, done_a;
  logic       tx_b, busy_b, done_b;
  logic       tx_c, busy_c, done_c;
  logic [1:0] sel;
  logic       tx_s, busy_s, done_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_50M = ~clk_50M;

  xbee_msg_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_a (
    .clk_50M(clk_50M), .rst_n(rst_n), .tx_start(start[0]), .msg_type(msg_type),
    .bin_number(bin_number), .colour(colour), .tx(tx_a), .busy(busy_a), .done(done_a));

  xbee_msg_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_b (
    .clk_50M(clk_50M), .rst_n(rst_n), .tx_start(start[1]), .msg_type(msg_type),
    .bin_number(bin_number), .colour(colour), .tx(tx_b), .busy(busy_b), .done(done_b));

  xbee_msg_tx #(.CLKS_PER_BIT(434), .STOP_BITS(2)) dut_c (
    .clk_50M(clk_50M), .rst_n(rst_n), .tx_start(start[2]), .msg_type(msg_type),
    .bin_number(bin_number), .colour(colour), .tx(tx_c), .busy(busy_c), .done(done_c));

  always_comb begin
    case (sel)
      2'd0:    begin tx_s = tx_a; busy_s = busy_a; done_s = done_a; end
      2'd1:    begin tx_s = tx_b; busy_s = busy_b; done_s = done_b; end
      default: begin tx_s = tx_c; busy_s = busy_c; done_s = done_c; end
    endcase
  end

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] t, input logic [3:0] b, input logic [1:0] c);
    msg_type   = t;
    bin_number = b;
    colour     = c;
    start[sel] = 1'b1;
    @(posedge clk_50M); #1;
    start[sel] = 1'b0;
    check("accept_tx", int'(tx_s), 0);
    check("accept_busy", int'(busy_s), 1);
  endtask

  task automatic idle_check(input int cycles, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_50M); #1;
      if (tx_s !== 1'b1 || busy_s !== 1'b0 || done_s !== 1'b0) bad++;
    end
    check(tag, bad, 0);
  endtask

  // Called just after the accept edge; walks every cycle of the expected waveform.
  task automatic watch_msg(input string exp, input int cpb, input int sb,
                           input bit chain, input int repulse_at);
    int total, n, bad, flag_bad, bi, pos, ci;
    logic [7:0] e;
    logic [7:0] ch;
    logic exp_tx;
    total    = exp.len() * (9 + sb) * cpb;
    bad      = 0;
    flag_bad = 0;
    ch       = '0;
    for (n = 0; n < total; n++) begin
      bi  = n / cpb;
      pos = bi % (9 + sb);
      ci  = bi / (9 + sb);
      e   = exp[ci];
      if (pos == 0)      exp_tx = 1'b0;
      else if (pos <= 8) exp_tx = e[pos-1];
      else               exp_tx = 1'b1;
      if (tx_s !== exp_tx) bad++;
      if (busy_s !== 1'b1 || done_s !== 1'b0) flag_bad++;
      if ((n % cpb) == (cpb / 2) && pos >= 1 && pos <= 8) ch[pos-1] = tx_s;
      if ((n % cpb) == (cpb / 2) && pos == 8)
        check($sformatf("%s_char%0d", exp.substr(0, 2), ci), int'(ch), int'(e));
      if (n == repulse_at) start[sel] = 1'b1;
      else if (n == repulse_at + 1) start[sel] = 1'b0;
      @(posedge clk_50M); #1;
    end
    check("waveform", bad, 0);
    check("busy_during", flag_bad, 0);
    check("done_pulse", int'(done_s), 1);
    check("busy_end", int'(busy_s), 0);
    check("tx_end", int'(tx_s), 1);
    if (chain) begin
      start[sel] = 1'b1;
      @(posedge clk_50M); #1;
      start[sel] = 1'b0;
      check("chain_tx", int'(tx_s), 0);
    end else begin
      @(posedge clk_50M); #1;
      check("done_width", int'(done_s), 0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = '0;
    msg_type   = '0;
    bin_number = '0;
    colour     = '0;
    sel        = 2'd0;
    @(posedge clk_50M); #1;
    check("rst_tx_a", int'(tx_a), 1);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_done_a", int'(done_a), 0);
    check("rst_tx_c", int'(tx_c), 1);
    @(posedge clk_50M); #1;
    rst_n = 1'b1;
    @(posedge clk_50M); #1;

    // GBI, then POS with bin_number changed after accept
    issue(2'd0, 4'd3, 2'd0);
    watch_msg("GBI3-M-#\n", 4, 2, 1'b0, -10);
    issue(2'd1, 4'd0, 2'd0);
    bin_number = 4'd7;
    watch_msg("POS0-#\n", 4, 2, 1'b0, -10);

    sel = 2'd1;
    issue(2'd0, 4'd12, 2'd3);
    watch_msg("GBI?-X-#\n", 4, 1, 1'b0, -10);

    // reserved type is ignored
    sel = 2'd0;
    msg_type   = 2'd3;
    start[0]   = 1'b1;
    @(posedge clk_50M); #1;
    start[0]   = 1'b0;
    idle_check(20, "type3_idle");

    // re-request while busy is dropped
    issue(2'd2, 4'd5, 2'd1);
    watch_msg("END-#\n", 4, 2, 1'b0, 20);
    idle_check(40, "no_requeue");

    // reset in the 4th character; start held through reset must not win
    issue(2'd0, 4'd4, 2'd2);
    repeat (149) @(posedge clk_50M);
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx", int'(tx_a), 1);
    check("abort_busy", int'(busy_a), 0);
    msg_type = 2'd0;
    start[0] = 1'b1;
    @(posedge clk_50M); #1;
    start[0] = 1'b0;
    rst_n    = 1'b1;
    idle_check(60, "post_reset_idle");
    issue(2'd2, 4'd0, 2'd0);
    watch_msg("END-#\n", 4, 2, 1'b0, -10);

    // back-to-back through the done cycle
    issue(2'd1, 4'd9, 2'd2);
    msg_type   = 2'd0;
    bin_number = 4'd1;
    colour     = 2'd2;
    watch_msg("POS9-#\n", 4, 2, 1'b1, -10);
    watch_msg("GBI1-W-#\n", 4, 2, 1'b0, -10);

    // default timing: 9 x 11 x 434 = 42966 cycles
    sel = 2'd2;
    issue(2'd0, 4'd9, 2'd1);
    watch_msg("GBI9-D-#\n", 434, 2, 1'b0, -10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
